// File: rtl/bram_pkg.sv
// Shared constants for the bram_rdq buffer: collision-policy encodings and the
// elaboration-time parameter legality check.
package bram_pkg;

  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;

  // Credits must cover every response that can be in the pipe plus the one being presented.
  function automatic bit params_ok(input int dw, input int bw, input int lat,
                                   input int od, input int wm);
    return (bw > 0) && (dw % bw == 0) && (lat >= 1) && (lat <= 3) &&
           (od >= lat + 1) && ((wm == WM_READ_FIRST) || (wm == WM_WRITE_FIRST));
  endfunction

endpackage

// File: rtl/bram_core.sv
// RAM array with byte-enable writes, read/write collision merge and a fixed
// READ_LATENCY data pipeline tagged by the base_vlat valid shift chain.
module bram_core
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int BYTE_WIDTH   = 8,
  parameter int RAM_DEPTH    = 512,
  parameter int ADDR_WIDTH   = $clog2(RAM_DEPTH),
  parameter int READ_LATENCY = 2,
  parameter int WRITE_MODE   = WM_READ_FIRST,
  localparam int NB          = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk2x,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [NB-1:0]         i_wbe,
  input  logic [ADDR_WIDTH-1:0] i_wa,
  input  logic [DATA_WIDTH-1:0] i_wd,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_ra,
  output logic                  o_v,
  output logic [DATA_WIDTH-1:0] o_d
);

  logic [DATA_WIDTH-1:0]   r_mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]   r_dpipe [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_base_vlat;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic                    w_coll;

  // Only write_first forwards the incoming bytes; read_first sees the pre-edge array.
  assign w_coll = i_we && (i_wa == i_ra) && (WRITE_MODE == WM_WRITE_FIRST);

  always_comb begin
    w_rdata = r_mem[i_ra];
    for (int b = 0; b < NB; b++) begin
      if (w_coll && i_wbe[b]) begin
        w_rdata[b*BYTE_WIDTH +: BYTE_WIDTH] = i_wd[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk2x) begin
    if (i_we) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_wa][b*BYTE_WIDTH +: BYTE_WIDTH] <= i_wd[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk2x or posedge reset) begin
    if (reset) begin
      r_base_vlat <= '0;
      for (int s = 0; s < READ_LATENCY; s++) begin
        r_dpipe[s] <= '0;
      end
    end else begin
      r_base_vlat[0] <= i_re;
      if (i_re) begin
        r_dpipe[0] <= w_rdata;
      end
      // Data stages only move with their valid so the last response stays on o_d.
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_base_vlat[s] <= r_base_vlat[s-1];
        if (r_base_vlat[s-1]) begin
          r_dpipe[s] <= r_dpipe[s-1];
        end
      end
    end
  end

  assign o_v = r_base_vlat[READ_LATENCY-1];
  assign o_d = r_dpipe[READ_LATENCY-1];

endmodule

// File: rtl/bram_rdq.sv
// Flow-controlled read buffer around bram_core: credit counter, bypassing FWFT
// skid FIFO and output mux so responses survive consumer stalls in order.
module bram_rdq
  import bram_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int BYTE_WIDTH   = 8,
  parameter int RAM_DEPTH    = 512,
  parameter int ADDR_WIDTH   = $clog2(RAM_DEPTH),
  parameter int READ_LATENCY = 2,
  parameter int WRITE_MODE   = WM_READ_FIRST,
  parameter int OUT_DEPTH    = READ_LATENCY + 1,
  localparam int NB          = DATA_WIDTH / BYTE_WIDTH,
  localparam int CW          = $clog2(OUT_DEPTH + 1)
) (
  input  logic                  clk2x,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [NB-1:0]         i_wbe,
  input  logic [ADDR_WIDTH-1:0] i_wa,
  input  logic [DATA_WIDTH-1:0] i_wd,
  input  logic                  i_rv,
  output logic                  o_rr,
  input  logic [ADDR_WIDTH-1:0] i_ra,
  output logic                  o_rv,
  input  logic                  i_rr,
  output logic [DATA_WIDTH-1:0] o_rd,
  output logic [CW-1:0]         o_cnt
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  if (!params_ok(DATA_WIDTH, BYTE_WIDTH, READ_LATENCY, OUT_DEPTH, WRITE_MODE)) begin : g_param_err
    $error("bram_rdq: illegal parameter combination");
  end

  logic                  w_accept, w_pop, w_push, w_fpop, w_fempty, w_lv;
  logic [DATA_WIDTH-1:0] w_ld;
  logic [CW-1:0]         r_cnt, r_fcnt;
  logic [PW-1:0]         r_wp, r_rp;
  logic [DATA_WIDTH-1:0] r_fifo [OUT_DEPTH];

  bram_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .BYTE_WIDTH  (BYTE_WIDTH),
    .RAM_DEPTH   (RAM_DEPTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .WRITE_MODE  (WRITE_MODE)
  ) u_core (
    .clk2x(clk2x),
    .reset(reset),
    .i_we (i_we),
    .i_wbe(i_wbe),
    .i_wa (i_wa),
    .i_wd (i_wd),
    .i_re (w_accept),
    .i_ra (i_ra),
    .o_v  (w_lv),
    .o_d  (w_ld)
  );

  // Handshake: a beat transfers on a rising edge where valid and ready are both 1;
  // o_rr comes from registered credits only, and o_rv/o_rd hold while o_rv=1 and i_rr=0.
  assign o_rr     = !reset && (r_cnt < CW'(OUT_DEPTH));
  assign w_accept = i_rv && o_rr;
  assign w_fempty = (r_fcnt == '0);
  assign o_rv     = w_fempty ? w_lv : 1'b1;
  assign o_rd     = w_fempty ? w_ld : r_fifo[r_rp];
  assign w_pop    = o_rv && i_rr;
  assign w_fpop   = w_pop && !w_fempty;
  assign w_push   = w_lv && !(w_fempty && i_rr);
  assign o_cnt    = r_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk2x or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_fcnt <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
    end else begin
      r_cnt  <= r_cnt + CW'(w_accept) - CW'(w_pop);
      r_fcnt <= r_fcnt + CW'(w_push) - CW'(w_fpop);
      if (w_push) r_wp <= ptr_inc(r_wp);
      if (w_fpop) r_rp <= ptr_inc(r_rp);
    end
  end

  always_ff @(posedge clk2x) begin
    if (w_push) begin
      r_fifo[r_wp] <= w_ld;
    end
  end

  a_no_accept_when_full: assert property (@(posedge clk2x) disable iff (reset)
    !(w_accept && (r_cnt == CW'(OUT_DEPTH))));
  a_no_fifo_overflow: assert property (@(posedge clk2x) disable iff (reset)
    !(w_push && !w_fpop && (r_fcnt == CW'(OUT_DEPTH))));

endmodule

// File: tb/tb_bram_rdq.sv
// Bench for bram_rdq: a read_first and a write_first instance share stimulus and
// are checked every cycle against a queue-based response model, plus literal checks.
module tb_bram_rdq;

  localparam int DW    = 64;
  localparam int BW    = 8;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int LAT   = 2;
  localparam int OD    = 3;
  localparam int NB    = DW / BW;
  localparam int CW    = 2;

  logic          clk2x = 1'b0;
  logic          reset = 1'b1;
  logic          i_we = 1'b0;
  logic [NB-1:0] i_wbe = '0;
  logic [AW-1:0] i_wa = '0;
  logic [DW-1:0] i_wd = '0;
  logic          i_rv = 1'b0;
  logic [AW-1:0] i_ra = '0;
  logic          i_rr = 1'b0;
  logic          o_rr0, o_rv0, o_rr1, o_rv1;
  logic [DW-1:0] o_rd0, o_rd1;
  logic [CW-1:0] o_cnt0, o_cnt1;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk2x = ~clk2x;

  bram_rdq #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
             .READ_LATENCY(LAT), .WRITE_MODE(0), .OUT_DEPTH(OD)) dut0 (
    .clk2x(clk2x), .reset(reset), .i_we(i_we), .i_wbe(i_wbe), .i_wa(i_wa), .i_wd(i_wd),
    .i_rv(i_rv), .o_rr(o_rr0), .i_ra(i_ra), .o_rv(o_rv0), .i_rr(i_rr), .o_rd(o_rd0),
    .o_cnt(o_cnt0));

  bram_rdq #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW),
             .READ_LATENCY(LAT), .WRITE_MODE(1), .OUT_DEPTH(OD)) dut1 (
    .clk2x(clk2x), .reset(reset), .i_we(i_we), .i_wbe(i_wbe), .i_wa(i_wa), .i_wd(i_wd),
    .i_rv(i_rv), .o_rr(o_rr1), .i_ra(i_ra), .o_rv(o_rv1), .i_rr(i_rr), .o_rd(o_rd1),
    .o_cnt(o_cnt1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / model ----------------
  // Outstanding responses in accept order; each becomes presentable LAT cycles after accept.
  logic [DW-1:0] mdl_mem [DEPTH];
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  int            avail_q[$];
  logic [DW-1:0] rsp_log[$];
  int            cyc = 0;

  always @(negedge clk2x) begin : p_check
    logic [DW-1:0] old_d, new_d;
    bit exp_rv, acc, pop;
    if (reset) begin
      chk("rst_rr0", o_rr0, 0);  chk("rst_rv0", o_rv0, 0);  chk("rst_cnt0", o_cnt0, 0);
      chk("rst_rr1", o_rr1, 0);  chk("rst_rv1", o_rv1, 0);  chk("rst_cnt1", o_cnt1, 0);
      exp_q0.delete(); exp_q1.delete(); avail_q.delete();
    end else begin
      exp_rv = (exp_q0.size() > 0) && (avail_q[0] <= cyc);
      chk("rr0", o_rr0, 64'(exp_q0.size() < OD));
      chk("rr1", o_rr1, 64'(exp_q0.size() < OD));
      chk("rv0", o_rv0, 64'(exp_rv));
      chk("rv1", o_rv1, 64'(exp_rv));
      chk("cnt0", o_cnt0, 64'(exp_q0.size()));
      chk("cnt1", o_cnt1, 64'(exp_q0.size()));
      if (exp_rv) begin
        chk("rd0", o_rd0, exp_q0[0]);
        chk("rd1", o_rd1, exp_q1[0]);
      end
      if (o_rv0 && i_rr) rsp_log.push_back(o_rd0);
      pop = exp_rv && i_rr;
      acc = i_rv && (exp_q0.size() < OD);
      if (pop) begin
        void'(exp_q0.pop_front()); void'(exp_q1.pop_front()); void'(avail_q.pop_front());
      end
      if (acc) begin
        old_d = mdl_mem[i_ra];
        new_d = old_d;
        if (i_we && (i_wa == i_ra))
          for (int b = 0; b < NB; b++)
            if (i_wbe[b]) new_d[b*BW +: BW] = i_wd[b*BW +: BW];
        exp_q0.push_back(old_d);
        exp_q1.push_back(new_d);
        avail_q.push_back(cyc + LAT);
      end
      if (i_we)
        for (int b = 0; b < NB; b++)
          if (i_wbe[b]) mdl_mem[i_wa][b*BW +: BW] = i_wd[b*BW +: BW];
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk2x);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    i_we = 1'b1; i_wa = a; i_wd = d; i_wbe = be;
    step();
    i_we = 1'b0; i_wbe = '0;
  endtask

  // Single read with i_rr=1; any write already set up rides the accept cycle.
  task automatic rd_wait(input logic [AW-1:0] a, output logic [DW-1:0] d0,
                         output logic [DW-1:0] d1, output int lat);
    i_rv = 1'b1; i_ra = a; i_rr = 1'b1;
    step();
    i_rv = 1'b0; i_we = 1'b0; i_wbe = '0;
    lat = 0; d0 = '0; d1 = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk2x);
      lat++;
      if (o_rv0) break;
    end
    if (!o_rv0) chk("rsp_timeout", 0, 1);
    d0 = o_rd0; d1 = o_rd1;
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] d0, d1;
    int lat, nacc, drops, nrv;
    bit acc;

    repeat (3) @(posedge clk2x);
    #1 reset = 1'b0;
    @(negedge clk2x);
    chk("rr_after_reset", o_rr0, 1);
    chk("cnt_after_reset", o_cnt0, 0);
    step();

    for (int a = 0; a < DEPTH; a++) wr(AW'(a), {$urandom, $urandom}, '1);

    // 1: basic read latency
    wr(3, 64'hA5A5A5A5A5A5A5A5, '1);
    rd_wait(3, d0, d1, lat);
    chk("t1_latency", 64'(lat), LAT);
    chk("t1_data", d0, 64'hA5A5A5A5A5A5A5A5);
    @(negedge clk2x);
    chk("t1_cnt_zero", o_cnt0, 0);
    step();

    // 2: byte enables
    wr(7, 64'h1111111111111111, '1);
    wr(7, 64'hFFFFFFFFFFFFFFFF, 8'h0F);
    rd_wait(7, d0, d1, lat);
    chk("t2_wbe_merge", d0, 64'h11111111FFFFFFFF);

    // 3: same-cycle collision
    wr(5, 64'h0, '1);
    i_we = 1'b1; i_wa = 5; i_wd = 64'hBEEF; i_wbe = '1;
    rd_wait(5, d0, d1, lat);
    chk("t3_read_first", d0, 64'h0);
    chk("t3_write_first", d1, 64'hBEEF);
    rd_wait(5, d0, d1, lat);
    chk("t3_next_cycle_visible", d0, 64'hBEEF);

    // 4: backpressure with credits
    for (int k = 0; k < 10; k++) wr(AW'(k), 64'hC0DE000000000000 + 64'(k), '1);
    rsp_log.delete();
    i_rr = 1'b0; i_rv = 1'b1; i_ra = 0; nacc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk2x); acc = o_rr0;
      step();
      if (acc) begin nacc++; i_ra = AW'(nacc); end
    end
    @(negedge clk2x);
    chk("t4_accepts", 64'(nacc), 3);
    chk("t4_rr_low", o_rr0, 0);
    chk("t4_cnt_full", o_cnt0, 3);
    step();
    i_rr = 1'b1;
    for (int k = 0; k < 60 && nacc < 10; k++) begin
      @(negedge clk2x); acc = o_rr0;
      step();
      if (acc) begin nacc++; i_ra = AW'(nacc); end
      if (nacc == 10) i_rv = 1'b0;
    end
    i_rv = 1'b0;
    for (int k = 0; k < 30 && rsp_log.size() < 10; k++) step();
    chk("t4_rsp_count", 64'(rsp_log.size()), 10);
    for (int k = 0; k < 10 && k < rsp_log.size(); k++)
      chk("t4_rsp_order", rsp_log[k], 64'hC0DE000000000000 + 64'(k));

    // 5: streaming throughput
    for (int k = 0; k < 100; k++) wr(AW'(16 + k), 64'h5000 + 64'(k), '1);
    rsp_log.delete();
    i_rr = 1'b1; i_rv = 1'b1; drops = 0;
    for (int k = 0; k < 100; k++) begin
      i_ra = AW'(16 + k);
      @(negedge clk2x);
      if (!o_rr0) drops++;
      if (k == 50) chk("t5_cnt_settles", o_cnt0, LAT);
      step();
    end
    i_rv = 1'b0;
    for (int k = 0; k < 30 && rsp_log.size() < 100; k++) step();
    chk("t5_rr_drops", 64'(drops), 0);
    chk("t5_rsp_count", 64'(rsp_log.size()), 100);
    for (int k = 0; k < 100 && k < rsp_log.size(); k++)
      chk("t5_rsp_data", rsp_log[k], 64'h5000 + 64'(k));

    // random traffic with collisions in a small address window
    for (int k = 0; k < 400; k++) begin
      i_we  = 1'($urandom_range(0, 1));
      i_wbe = NB'($urandom);
      i_wa  = AW'($urandom_range(0, 15));
      i_wd  = {$urandom, $urandom};
      i_rv  = 1'($urandom_range(0, 1));
      i_ra  = AW'($urandom_range(0, 15));
      i_rr  = ($urandom_range(0, 3) != 0);
      step();
    end
    i_we = 1'b0; i_wbe = '0; i_rv = 1'b0; i_rr = 1'b1;
    repeat (10) step();

    // 6: reset with two in flight and one queued
    i_rr = 1'b0; i_rv = 1'b1;
    i_ra = 20; step();
    i_ra = 21; step();
    i_ra = 22; step();
    i_rv = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_rv_in_reset", o_rv0, 0);
    chk("t6_cnt_in_reset", o_cnt0, 0);
    chk("t6_rr_in_reset", o_rr0, 0);
    step(); step();
    reset = 1'b0;
    @(negedge clk2x);
    chk("t6_rr_after_deassert", o_rr0, 1);
    i_rr = 1'b1; nrv = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk2x);
      if (o_rv0 || o_rv1) nrv++;
    end
    chk("t6_no_stale_rsp", 64'(nrv), 0);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
